rst_seq: RTL

- Reset sequencer that sits directly downstream of the reset synchronizer.
- Consumes the already-synchronized reset of one clock domain and the domain's soft-reset requests.
- Drives NUM_STAGES ordered, active-high stage resets, each with a guaranteed minimum hold time.
- Releases stages one at a time; after each release it waits for that stage's ready handshake, bounded by a timeout.

---
 rtl/rst_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rst_seq.sv
// Reset sequencer: holds all stage resets, then releases them in order,
// waiting for each stage's ready (bounded by a timeout) before the next.
module rst_seq #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_DELAY = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_rdy,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  all_rdy,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] err_stage
);

   localparam int KW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int MAX1 = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int MAXC = (MAX1 > TIMEOUT) ? MAX1 : TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_DELAY);
   localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      HOLD,
      WAIT_RDY,
      GAP,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [KW-1:0]   k_q, k_d, k_inc;
   logic [NUM_STAGES-1:0] stage_rst_d;
   logic            all_rdy_d, busy_d, timeout_err_d;
   logic [KW-1:0]   err_stage_d;
   logic            proceed;

   assign k_inc = k_q + KW'(1);

   // Next-state and next-output logic; soft requests override every state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      k_d           = k_q;
      stage_rst_d   = stage_rst;
      all_rdy_d     = all_rdy;
      timeout_err_d = timeout_err;
      err_stage_d   = err_stage;
      proceed       = 1'b0;
      if (soft_rst_req) begin
         state_d     = HOLD;
         cnt_d       = '0;
         k_d         = '0;
         stage_rst_d = '1;
         all_rdy_d   = 1'b0;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  stage_rst_d[0] = 1'b0;
                  k_d            = '0;
                  cnt_d          = '0;
                  state_d        = WAIT_RDY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            WAIT_RDY: begin
               if (stage_rdy[k_q]) begin
                  proceed = 1'b1;
               end else if (cnt_q == TO_LAST) begin
                  proceed       = 1'b1;
                  timeout_err_d = 1'b1;
                  if (!timeout_err) err_stage_d = k_q;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
               // Timeout is fail-open: advance just as if ready was seen.
               if (proceed) begin
                  cnt_d = '0;
                  if (k_q == K_LAST) begin
                     state_d   = DONE;
                     all_rdy_d = 1'b1;
                  end else if (STAGE_DELAY == 0) begin
                     stage_rst_d[k_inc] = 1'b0;
                     k_d                = k_inc;
                  end else begin
                     state_d = GAP;
                  end
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  stage_rst_d[k_inc] = 1'b0;
                  k_d                = k_inc;
                  cnt_d              = '0;
                  state_d            = WAIT_RDY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DONE: begin
               state_d = DONE;
            end
         endcase
      end
      busy_d = (state_d != DONE);
   end

   // State and registered outputs; rst also clears the sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         k_q         <= '0;
         stage_rst   <= '1;
         all_rdy     <= 1'b0;
         busy        <= 1'b1;
         timeout_err <= 1'b0;
         err_stage   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         stage_rst   <= stage_rst_d;
         all_rdy     <= all_rdy_d;
         busy        <= busy_d;
         timeout_err <= timeout_err_d;
         err_stage   <= err_stage_d;
      end
   end

endmodule
